flow_table_mem: RTL and testbench

- Responder end of the processor's table-memory interface (ce/we/addr/width/data).
- Byte-addressable flow-table storage. The matcher inside the processor issues reads; this block returns data with fixed 1-cycle latency.
- A control-plane management write port loads flow entries through a small FIFO. Queued writes drain only in cycles when the processor port is idle.

---
 rtl/flow_table_mem.sv | 235 +++++++++++++++++++++++
 tb/tb_flow_table_mem.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flow_table_mem.sv
// flow_table_mem: byte-addressable flow-table storage. It answers the
// processor's ce/we/addr/width/data port with a fixed one-cycle read latency.
// It also accepts control-plane writes through a small FIFO, which drains
// only while the processor port is idle.
//
// Optional build macro FLOW_MEM_PARITY_EN adds one even-parity bit per
// stored byte, a sticky parity_err_o output and a parity_inject_i input.
//
// Handshake: a management entry is accepted on every rising edge where
// mgmt_wr_valid_i && mgmt_wr_ready_o. mgmt_wr_ready_o depends only on the
// registered FIFO level, never on mgmt_wr_valid_i.
//
// Byte order is big-endian. For an access of width w at address a, byte a
// maps to data bits [8w-1:8w-8] and byte a+w-1 maps to bits [7:0].
module flow_table_mem #(
    parameter int DEPTH_BYTES = 4096,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mem_ce_i,
    input  logic                          mem_we_i,
    input  logic [31:0]                   mem_addr_i,
    input  logic [3:0]                    mem_width_i,
    input  logic [31:0]                   mem_data_i,
    output logic [31:0]                   mem_data_o,
    input  logic                          mgmt_wr_valid_i,
    output logic                          mgmt_wr_ready_o,
    input  logic [31:0]                   mgmt_wr_addr_i,
    input  logic [3:0]                    mgmt_wr_width_i,
    input  logic [31:0]                   mgmt_wr_data_i,
    output logic [$clog2(FIFO_DEPTH):0]   mgmt_level_o,
`ifdef FLOW_MEM_PARITY_EN
    output logic                          parity_err_o,
    input  logic                          parity_inject_i,
`endif
    output logic                          addr_err_o,
    input  logic                          err_clr_i
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    // Legal widths are 1, 2 and 4. The sum is computed in 33 bits so that a
    // high address cannot wrap around and look legal.
    function automatic logic access_ok(input logic [31:0] addr, input logic [3:0] width);
        logic [32:0] last;
        last = {1'b0, addr} + {29'd0, width};
        return ((width == 4'd1) || (width == 4'd2) || (width == 4'd4)) &&
               (last <= 33'(DEPTH_BYTES));
    endfunction

    logic [7:0]    mem [DEPTH_BYTES];

    logic [31:0]   q_addr  [FIFO_DEPTH];
    logic [3:0]    q_width [FIFO_DEPTH];
    logic [31:0]   q_data  [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] level;

    logic          push;
    logic          pop;
    logic          proc_rd;
    logic          proc_wr;
    logic          proc_ok;
    logic          head_ok;
    logic          err_set;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [3:0]    wr_width;
    logic [31:0]   wr_data;
    logic [5:0]    wr_shamt;
    logic [31:0]   wr_aligned;

    // The read request is captured at the sampling edge and resolved at the
    // following edge.
    logic          rd_pend;
    logic          rd_ok_q;
    logic [AW-1:0] rd_addr_q;
    logic [3:0]    rd_width_q;
    logic [31:0]   rd_word;

    assign mgmt_wr_ready_o = (level != LW'(FIFO_DEPTH));
    assign mgmt_level_o    = level;
    assign push    = mgmt_wr_valid_i && mgmt_wr_ready_o;
    assign pop     = !mem_ce_i && (level != '0);
    assign proc_rd = mem_ce_i && !mem_we_i;
    assign proc_wr = mem_ce_i && mem_we_i;
    assign proc_ok = access_ok(mem_addr_i, mem_width_i);
    assign head_ok = access_ok(q_addr[rd_ptr], q_width[rd_ptr]);
    assign err_set = (mem_ce_i && !proc_ok) || (pop && !head_ok);

    // Storage write source. A processor write and a FIFO pop are mutually
    // exclusive because a pop requires the port to be idle.
    always_comb begin
        wr_en    = 1'b0;
        wr_addr  = mem_addr_i[AW-1:0];
        wr_width = mem_width_i;
        wr_data  = mem_data_i;
        if (proc_wr) begin
            wr_en = proc_ok;
        end else if (pop) begin
            wr_en    = head_ok;
            wr_addr  = q_addr[rd_ptr][AW-1:0];
            wr_width = q_width[rd_ptr];
            wr_data  = q_data[rd_ptr];
        end
    end

    // Left-justify the right-aligned write data so that byte i of the access
    // always sits at bits [31-8i -: 8].
    assign wr_shamt   = 6'd32 - {wr_width[2:0], 3'b000};
    assign wr_aligned = wr_data << wr_shamt;

    // Assemble the pending read, shifting bytes in from the lowest address.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < int'(rd_width_q)) begin
                rd_word = {rd_word[23:0], mem[rd_addr_q + AW'(i)]};
            end
        end
    end

`ifdef FLOW_MEM_PARITY_EN
    logic mem_par [DEPTH_BYTES];
    logic inject_arm;
    logic inject_now;
    logic rd_par_bad;

    assign inject_now = parity_inject_i || inject_arm;

    // Recompute parity on every byte of the pending read.
    always_comb begin
        rd_par_bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i < int'(rd_width_q)) begin
                if ((^mem[rd_addr_q + AW'(i)]) != mem_par[rd_addr_q + AW'(i)]) begin
                    rd_par_bad = 1'b1;
                end
            end
        end
    end

    // An inject request stays armed until the next write completes. The
    // parity error flag is sticky, and a set wins over a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inject_arm   <= 1'b0;
            parity_err_o <= 1'b0;
        end else begin
            if (wr_en) begin
                inject_arm <= 1'b0;
            end else if (parity_inject_i) begin
                inject_arm <= 1'b1;
            end
            if (rd_pend && rd_ok_q && rd_par_bad) begin
                parity_err_o <= 1'b1;
            end else if (err_clr_i) begin
                parity_err_o <= 1'b0;
            end
        end
    end
`endif

    // Byte storage. It has no reset: the contents are undefined after reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (i < int'(wr_width)) begin
                    mem[wr_addr + AW'(i)] <= wr_aligned[31-8*i -: 8];
`ifdef FLOW_MEM_PARITY_EN
                    mem_par[wr_addr + AW'(i)] <= (^wr_aligned[31-8*i -: 8]) ^ inject_now;
`endif
                end
            end
        end
    end

    // FIFO entry storage. Validity is tracked by the pointers and the level.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr]  <= mgmt_wr_addr_i;
            q_width[wr_ptr] <= mgmt_wr_width_i;
            q_data[wr_ptr]  <= mgmt_wr_data_i;
        end
    end

    // Control state: FIFO pointers and level, read pipeline, sticky address error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            rd_pend    <= 1'b0;
            rd_ok_q    <= 1'b0;
            rd_addr_q  <= '0;
            rd_width_q <= '0;
            mem_data_o <= '0;
            addr_err_o <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase

            rd_pend <= proc_rd;
            if (proc_rd) begin
                rd_ok_q    <= proc_ok;
                rd_addr_q  <= mem_addr_i[AW-1:0];
                rd_width_q <= mem_width_i;
            end
            if (rd_pend) begin
                mem_data_o <= rd_ok_q ? rd_word : 32'd0;
            end

            if (err_set) begin
                addr_err_o <= 1'b1;
            end else if (err_clr_i) begin
                addr_err_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_flow_table_mem.sv
// Testbench for flow_table_mem. A behavioural model (byte array, request
// queue, sticky flag) advances one clock at a time alongside the DUT. Each
// scenario task drives inputs and compares the DUT outputs inline.
module tb_flow_table_mem;

    localparam int DEPTH = 4096;
    localparam int FD    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_ce_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [31:0] mem_addr_i = '0;
    logic [3:0]  mem_width_i = '0;
    logic [31:0] mem_data_i = '0;
    logic [31:0] mem_data_o;
    logic        mgmt_wr_valid_i = 1'b0;
    logic        mgmt_wr_ready_o;
    logic [31:0] mgmt_wr_addr_i = '0;
    logic [3:0]  mgmt_wr_width_i = '0;
    logic [31:0] mgmt_wr_data_i = '0;
    logic [2:0]  mgmt_level_o;
    logic        addr_err_o;
    logic        err_clr_i = 1'b0;
`ifdef FLOW_MEM_PARITY_EN
    logic        parity_err_o;
    logic        parity_inject_i = 1'b0;
`endif

    flow_table_mem #(.DEPTH_BYTES(DEPTH), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst),
        .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_width_i(mem_width_i), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
        .mgmt_wr_valid_i(mgmt_wr_valid_i), .mgmt_wr_ready_o(mgmt_wr_ready_o),
        .mgmt_wr_addr_i(mgmt_wr_addr_i), .mgmt_wr_width_i(mgmt_wr_width_i),
        .mgmt_wr_data_i(mgmt_wr_data_i), .mgmt_level_o(mgmt_level_o),
`ifdef FLOW_MEM_PARITY_EN
        .parity_err_o(parity_err_o), .parity_inject_i(parity_inject_i),
`endif
        .addr_err_o(addr_err_o), .err_clr_i(err_clr_i)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model state
    typedef struct {
        logic [31:0] a;
        logic [3:0]  w;
        logic [31:0] d;
    } req_t;

    logic [7:0]  mm [DEPTH];
    req_t        mq [$];
    logic [31:0] exp_data = '0;
    logic        exp_err  = 1'b0;
    bit          pend = 1'b0;
    bit          pend_ok = 1'b0;
    logic [31:0] pend_a = '0;
    logic [3:0]  pend_w = '0;
    int          checks = 0;
    int          errors = 0;

    function automatic bit legal_m(input logic [31:0] a, input logic [3:0] w);
        return ((w == 4'd1) || (w == 4'd2) || (w == 4'd4)) &&
               (({32'd0, a} + 64'(w)) <= 64'(DEPTH));
    endfunction

    function automatic logic [31:0] mread(input logic [31:0] a, input logic [3:0] w);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < int'(w); k++) r = (r << 8) | 32'(mm[int'(a) + k]);
        return r;
    endfunction

    task automatic mwrite(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        for (int k = 0; k < int'(w); k++) mm[int'(a) + k] = 8'(d >> (8 * (int'(w) - 1 - k)));
    endtask

    // Advance the model by one clock using the currently driven inputs, then
    // step the DUT through the same edge and settle.
    task automatic step();
        bit   err_set;
        int   sz;
        bit   can_push;
        req_t h;
        err_set  = 1'b0;
        sz       = mq.size();
        can_push = (sz != FD);
        if (pend) begin
            exp_data = pend_ok ? mread(pend_a, pend_w) : 32'd0;
            pend = 1'b0;
        end
        if (mem_ce_i && !mem_we_i) begin
            pend    = 1'b1;
            pend_a  = mem_addr_i;
            pend_w  = mem_width_i;
            pend_ok = legal_m(mem_addr_i, mem_width_i);
            if (!pend_ok) err_set = 1'b1;
        end
        if (mem_ce_i && mem_we_i) begin
            if (legal_m(mem_addr_i, mem_width_i)) mwrite(mem_addr_i, mem_width_i, mem_data_i);
            else err_set = 1'b1;
        end
        if (!mem_ce_i && sz > 0) begin
            h = mq.pop_front();
            if (legal_m(h.a, h.w)) mwrite(h.a, h.w, h.d);
            else err_set = 1'b1;
        end
        if (mgmt_wr_valid_i && can_push) begin
            h.a = mgmt_wr_addr_i;
            h.w = mgmt_wr_width_i;
            h.d = mgmt_wr_data_i;
            mq.push_back(h);
        end
        if (err_set) exp_err = 1'b1;
        else if (err_clr_i) exp_err = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        pend     = 1'b0;
        exp_data = '0;
        exp_err  = 1'b0;
    endtask

    // Driver tasks
    task automatic drive_idle();
        mem_ce_i        = 1'b0;
        mem_we_i        = 1'b0;
        mgmt_wr_valid_i = 1'b0;
        err_clr_i       = 1'b0;
`ifdef FLOW_MEM_PARITY_EN
        parity_inject_i = 1'b0;
`endif
    endtask

    task automatic drive_proc(input bit we, input logic [31:0] a, input logic [3:0] w,
                              input logic [31:0] d);
        mem_ce_i    = 1'b1;
        mem_we_i    = we;
        mem_addr_i  = a;
        mem_width_i = w;
        mem_data_i  = d;
    endtask

    task automatic drive_mgmt(input bit v, input logic [31:0] a, input logic [3:0] w,
                              input logic [31:0] d);
        mgmt_wr_valid_i = v;
        mgmt_wr_addr_i  = a;
        mgmt_wr_width_i = w;
        mgmt_wr_data_i  = d;
    endtask

    // Scenarios
    task automatic test_reset();
        checks++; if (mem_data_o !== 32'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", mem_data_o); end
        checks++; if (mgmt_wr_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", mgmt_wr_ready_o); end
        checks++; if (mgmt_level_o !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", mgmt_level_o); end
        checks++; if (addr_err_o !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", addr_err_o); end
    endtask

    task automatic test_mgmt_basic();
        drive_idle();
        drive_mgmt(1'b1, 32'h10, 4'd4, 32'hDEADBEEF);
        step();
        drive_idle();
        checks++; if (mgmt_level_o !== 3'd1) begin errors++; $display("FAIL mgmt_level_push got=%0d exp=1", mgmt_level_o); end
        step();
        checks++; if (mgmt_level_o !== 3'd0) begin errors++; $display("FAIL mgmt_level_pop got=%0d exp=0", mgmt_level_o); end
        drive_proc(1'b0, 32'h10, 4'd4, 32'd0);
        step();
        drive_proc(1'b0, 32'h11, 4'd2, 32'd0);
        checks++; if (mem_data_o !== 32'd0) begin errors++; $display("FAIL read_latency got=%h exp=0", mem_data_o); end
        step();
        drive_idle();
        checks++; if (mem_data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL mgmt_read_w4 got=%h exp=deadbeef", mem_data_o); end
        step();
        checks++; if (mem_data_o !== 32'h0000ADBE) begin errors++; $display("FAIL mgmt_read_w2 got=%h exp=0000adbe", mem_data_o); end
        step();
        checks++; if (mem_data_o !== 32'h0000ADBE) begin errors++; $display("FAIL read_hold got=%h exp=0000adbe", mem_data_o); end
    endtask

    task automatic test_proc_write();
        drive_proc(1'b1, 32'h20, 4'd1, 32'hFFFF_FF5A);
        step();
        drive_proc(1'b0, 32'h20, 4'd4, 32'd0);
        step();
        drive_idle();
        step();
        checks++; if (mem_data_o[31:24] !== 8'h5A) begin errors++; $display("FAIL proc_write_byte got=%h exp=5a", mem_data_o[31:24]); end
    endtask

    // Five pushes while reads hold the port, then drain and read back-to-back.
    task automatic test_back_to_back();
        logic [31:0] d;
        drive_proc(1'b1, 32'h50, 4'd4, 32'h12345678); step();
        drive_proc(1'b1, 32'h60, 4'd4, 32'h0BADF00D); step();
        drive_proc(1'b0, 32'h50, 4'd4, 32'd0);
        for (int k = 0; k < 5; k++) begin
            d = $urandom;
            checks++; if (mgmt_wr_ready_o !== (k < 4)) begin errors++; $display("FAIL bp_ready_%0d got=%b exp=%b", k, mgmt_wr_ready_o, (k < 4)); end
            drive_mgmt(1'b1, 32'h50 + 32'(4 * k), 4'd4, d);
            step();
        end
        mgmt_wr_valid_i = 1'b0;
        step();
        checks++; if (mgmt_level_o !== 3'd4) begin errors++; $display("FAIL bp_level_full got=%0d exp=4", mgmt_level_o); end
        checks++; if (mgmt_wr_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready_full got=%b exp=0", mgmt_wr_ready_o); end
        checks++; if (mem_data_o !== 32'h12345678) begin errors++; $display("FAIL bp_not_applied got=%h exp=12345678", mem_data_o); end
        drive_idle();
        step();
        checks++; if (mgmt_level_o !== 3'd3) begin errors++; $display("FAIL bp_level_pop1 got=%0d exp=3", mgmt_level_o); end
        checks++; if (mgmt_wr_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_return got=%b exp=1", mgmt_wr_ready_o); end
        for (int k = 0; k < 3; k++) step();
        checks++; if (mgmt_level_o !== 3'd0) begin errors++; $display("FAIL bp_level_empty got=%0d exp=0", mgmt_level_o); end
        for (int k = 0; k < 6; k++) begin
            if (k < 5) drive_proc(1'b0, 32'h50 + 32'(4 * k), 4'd4, 32'd0);
            else drive_idle();
            step();
            if (k > 0) begin
                checks++; if (mem_data_o !== exp_data) begin errors++; $display("FAIL b2b_read_%0d got=%h exp=%h", k - 1, mem_data_o, exp_data); end
            end
        end
        checks++; if (mem_data_o !== 32'h0BADF00D) begin errors++; $display("FAIL bp_fifth_dropped got=%h exp=0badf00d", mem_data_o); end
    endtask

    task automatic test_illegal();
        drive_proc(1'b1, 32'(DEPTH - 4), 4'd4, 32'hCAFEF00D); step();
        drive_proc(1'b1, 32'h40, 4'd4, 32'h11223344); step();
        drive_proc(1'b0, 32'(DEPTH - 4), 4'd4, 32'd0); step();
        drive_idle(); step();
        checks++; if (mem_data_o !== 32'hCAFEF00D) begin errors++; $display("FAIL edge_read got=%h exp=cafef00d", mem_data_o); end
        checks++; if (addr_err_o !== 1'b0) begin errors++; $display("FAIL edge_no_err got=%b exp=0", addr_err_o); end
        drive_proc(1'b0, 32'(DEPTH - 2), 4'd4, 32'd0); step();
        drive_idle();
        checks++; if (addr_err_o !== 1'b1) begin errors++; $display("FAIL oob_err got=%b exp=1", addr_err_o); end
        step();
        checks++; if (mem_data_o !== 32'd0) begin errors++; $display("FAIL oob_data got=%h exp=0", mem_data_o); end
        drive_proc(1'b1, 32'h40, 4'd3, 32'h00AABBCC); step();
        drive_proc(1'b0, 32'h40, 4'd4, 32'd0); step();
        drive_idle(); step();
        checks++; if (mem_data_o !== 32'h11223344) begin errors++; $display("FAIL w3_dropped got=%h exp=11223344", mem_data_o); end
        checks++; if (addr_err_o !== 1'b1) begin errors++; $display("FAIL w3_err_sticky got=%b exp=1", addr_err_o); end
        drive_proc(1'b0, 32'h40, 4'd0, 32'd0);
        err_clr_i = 1'b1;
        step();
        drive_idle();
        checks++; if (addr_err_o !== 1'b1) begin errors++; $display("FAIL set_wins got=%b exp=1", addr_err_o); end
        err_clr_i = 1'b1; step(); err_clr_i = 1'b0;
        checks++; if (addr_err_o !== 1'b0) begin errors++; $display("FAIL err_clear got=%b exp=0", addr_err_o); end
        drive_mgmt(1'b1, 32'hFFFF_FFFE, 4'd4, 32'h55555555); step();
        drive_idle();
        checks++; if (addr_err_o !== 1'b0) begin errors++; $display("FAIL mgmt_err_early got=%b exp=0", addr_err_o); end
        step();
        checks++; if (addr_err_o !== 1'b1) begin errors++; $display("FAIL mgmt_wrap_err got=%b exp=1", addr_err_o); end
        err_clr_i = 1'b1; step(); err_clr_i = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0]  w;
        logic [31:0] a;
        int          r;
        drive_idle();
        for (int k = 0; k < 32; k++) begin
            drive_proc(1'b1, 32'h100 + 32'(4 * k), 4'd4, $urandom);
            step();
        end
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 2))
                0: w = 4'd1;
                1: w = 4'd2;
                default: w = 4'd4;
            endcase
            a = 32'h100 + 32'($urandom_range(0, 128 - int'(w)));
            r = $urandom_range(0, 99);
            if (r < 4) w = 4'd3;
            else if (r < 8) begin a = 32'(DEPTH - 1); w = 4'd2; end
            mem_ce_i    = ($urandom_range(0, 99) < 65);
            mem_we_i    = ($urandom_range(0, 2) == 0);
            mem_addr_i  = a;
            mem_width_i = w;
            mem_data_i  = $urandom;
            case ($urandom_range(0, 2))
                0: w = 4'd1;
                1: w = 4'd2;
                default: w = 4'd4;
            endcase
            drive_mgmt(1'($urandom_range(0, 1)), 32'h100 + 32'($urandom_range(0, 128 - int'(w))), w, $urandom);
            err_clr_i = ($urandom_range(0, 9) == 0);
            step();
            checks++; if (mem_data_o !== exp_data) begin errors++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", n, mem_data_o, exp_data); end
            checks++; if (mgmt_level_o !== 3'(mq.size())) begin errors++; $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d", n, mgmt_level_o, mq.size()); end
            checks++; if (mgmt_wr_ready_o !== (mq.size() != FD)) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b", n, mgmt_wr_ready_o); end
            checks++; if (addr_err_o !== exp_err) begin errors++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", n, addr_err_o, exp_err); end
        end
        drive_idle();
        for (int k = 0; k < 6; k++) step();
        checks++; if (mgmt_level_o !== 3'd0) begin errors++; $display("FAIL rnd_drained got=%0d exp=0", mgmt_level_o); end
    endtask

    task automatic test_async_reset();
        drive_idle();
        drive_proc(1'b0, 32'h10, 4'd4, 32'd0);
        for (int k = 0; k < 4; k++) begin
            drive_mgmt(1'b1, 32'h200 + 32'(4 * k), 4'd4, $urandom);
            step();
        end
        drive_idle();
        step();
        checks++; if (mgmt_level_o !== 3'd3) begin errors++; $display("FAIL ar_level_before got=%0d exp=3", mgmt_level_o); end
        checks++; if (mem_data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL ar_data_before got=%h exp=deadbeef", mem_data_o); end
        #3;
        rst = 1'b1;
        #1;
        checks++; if (mgmt_level_o !== 3'd0) begin errors++; $display("FAIL ar_level got=%0d exp=0", mgmt_level_o); end
        checks++; if (mgmt_wr_ready_o !== 1'b1) begin errors++; $display("FAIL ar_ready got=%b exp=1", mgmt_wr_ready_o); end
        checks++; if (mem_data_o !== 32'd0) begin errors++; $display("FAIL ar_data got=%h exp=0", mem_data_o); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        step();
        checks++; if (mgmt_level_o !== 3'd0) begin errors++; $display("FAIL ar_level_after got=%0d exp=0", mgmt_level_o); end
    endtask

`ifdef FLOW_MEM_PARITY_EN
    task automatic test_parity();
        drive_idle();
        err_clr_i = 1'b1; step(); err_clr_i = 1'b0;
        drive_proc(1'b1, 32'h30, 4'd1, 32'hA5);
        parity_inject_i = 1'b1;
        step();
        parity_inject_i = 1'b0;
        drive_proc(1'b0, 32'h30, 4'd1, 32'd0); step();
        drive_idle(); step();
        checks++; if (parity_err_o !== 1'b1) begin errors++; $display("FAIL par_inject got=%b exp=1", parity_err_o); end
        drive_proc(1'b1, 32'h31, 4'd1, 32'h3C); step();
        drive_proc(1'b0, 32'h31, 4'd1, 32'd0); step();
        drive_idle(); step();
        checks++; if (mem_data_o !== 32'h3C) begin errors++; $display("FAIL par_clean_data got=%h exp=3c", mem_data_o); end
        checks++; if (parity_err_o !== 1'b1) begin errors++; $display("FAIL par_sticky got=%b exp=1", parity_err_o); end
        err_clr_i = 1'b1; step(); err_clr_i = 1'b0;
        checks++; if (parity_err_o !== 1'b0) begin errors++; $display("FAIL par_clear got=%b exp=0", parity_err_o); end
        drive_proc(1'b0, 32'h31, 4'd1, 32'd0); step();
        drive_idle(); step();
        checks++; if (parity_err_o !== 1'b0) begin errors++; $display("FAIL par_clean_read got=%b exp=0", parity_err_o); end
    endtask
`endif

    initial begin
        drive_idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_mgmt_basic();
        test_proc_write();
        test_back_to_back();
        test_illegal();
        test_random();
        test_async_reset();
`ifdef FLOW_MEM_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
